// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch command controller: FSM states, event codes, ASCII bytes.
// Also provides the case-folding helper used by the UART command decoder.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2
   } run_state_t;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_EXEC = 2'd1,
      F_ACK  = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_RUN  = 2'd1,
      EV_CLR  = 2'd2,
      EV_MODE = 2'd3
   } event_t;

   localparam logic [7:0] ASC_R    = 8'h52;
   localparam logic [7:0] ASC_C    = 8'h43;
   localparam logic [7:0] ASC_M    = 8'h4D;
   localparam logic [7:0] ASC_DASH = 8'h2D;
   localparam logic [7:0] ASC_QUES = 8'h3F;

   function automatic logic [7:0] to_upper(input logic [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7A)) ? (b - 8'h20) : b;
   endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// Combinational UART command decode: case-folds the byte, returns the event code and the
// uppercase echo byte ('?' for anything unrecognised). Zero latency, no flow control.
module uart_cmd_decoder
   import stopwatch_pkg::*;
#(
   parameter logic [7:0] CMD_RUN  = ASC_R,
   parameter logic [7:0] CMD_CLR  = ASC_C,
   parameter logic [7:0] CMD_MODE = ASC_M
)
(
   input  logic [7:0] cmd_byte,
   output event_t     cmd_ev,
   output logic [7:0] cmd_echo
);

   logic [7:0] folded;

   assign folded = to_upper(cmd_byte);

   always_comb begin
      cmd_ev   = EV_NONE;
      cmd_echo = ASC_QUES;
      if (folded == to_upper(CMD_RUN)) begin
         cmd_ev   = EV_RUN;
         cmd_echo = to_upper(CMD_RUN);
      end else if (folded == to_upper(CMD_CLR)) begin
         cmd_ev   = EV_CLR;
         cmd_echo = to_upper(CMD_CLR);
      end else if (folded == to_upper(CMD_MODE)) begin
         cmd_ev   = EV_MODE;
         cmd_echo = to_upper(CMD_MODE);
      end
   end

endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// Stopwatch controller: merges button edges and UART commands into the run/stop/clear FSM.
// Pop-to-state latency 2 cycles; buttons win over UART; a busy TX stalls further FIFO pops.
module stopwatch_cmd_ctrl
   import stopwatch_pkg::*;
#(
   parameter bit         ACK_EN   = 1'b1,
   parameter logic [7:0] CMD_RUN  = 8'h52,
   parameter logic [7:0] CMD_CLR  = 8'h43,
   parameter logic [7:0] CMD_MODE = 8'h4D
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_run_stop,
   input  logic       btn_clear,
   input  logic       btn_mode,
   input  logic       rx_empty,
   input  logic [7:0] rx_data,
   output logic       rx_rd,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       enable,
   output logic       clear,
   output logic       run_md,
   output logic [1:0] state
);

   logic [2:0]   btn_q;
   logic [2:0]   btn_ev;
   event_t       btn_code;
   event_t       uart_code;
   event_t       ev_apply;
   logic [7:0]   cmd_q;
   logic [7:0]   cmd_echo;
   logic [7:0]   ack_byte;
   logic         uart_go;
   run_state_t   run_state, run_next;
   fetch_state_t f_state, f_next;
   logic         md_next, enable_d, clear_d;

   uart_cmd_decoder #(
      .CMD_RUN  (CMD_RUN),
      .CMD_CLR  (CMD_CLR),
      .CMD_MODE (CMD_MODE)
   ) u_dec (
      .cmd_byte (cmd_q),
      .cmd_ev   (uart_code),
      .cmd_echo (cmd_echo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q  <= '0;
         btn_ev <= '0;
      end else begin
         btn_q  <= {btn_mode, btn_clear, btn_run_stop};
         btn_ev <= {btn_mode, btn_clear, btn_run_stop} & ~btn_q;
      end
   end

   // Simultaneous button edges collapse to one event: run, then clear, then mode.
   always_comb begin
      btn_code = EV_NONE;
      if (btn_ev[0])      btn_code = EV_RUN;
      else if (btn_ev[1]) btn_code = EV_CLR;
      else if (btn_ev[2]) btn_code = EV_MODE;
   end

   // A UART command waits out both a button event and the CLEAR cycle, so it is never lost.
   assign uart_go  = (f_state == F_EXEC) && (btn_code == EV_NONE) && (run_state != CLEAR);
   assign ev_apply = (btn_code != EV_NONE) ? btn_code : (uart_go ? uart_code : EV_NONE);

   // Run FSM: state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_state <= STOP;
         run_md    <= 1'b0;
         enable    <= 1'b0;
         clear     <= 1'b0;
      end else begin
         run_state <= run_next;
         run_md    <= md_next;
         enable    <= enable_d;
         clear     <= clear_d;
      end
   end

   // Run FSM: next state.
   always_comb begin
      run_next = run_state;
      md_next  = run_md;
      case (run_state)
         STOP: begin
            case (ev_apply)
               EV_RUN:  run_next = RUN;
               EV_CLR:  run_next = CLEAR;
               EV_MODE: md_next  = ~run_md;
               default: ;
            endcase
         end
         RUN:     if (ev_apply == EV_RUN) run_next = STOP;
         CLEAR:   run_next = STOP;
         default: run_next = STOP;
      endcase
   end

   // Run FSM: outputs, registered from the next state so they line up with state.
   always_comb begin
      enable_d = (run_next == RUN);
      clear_d  = (run_next == CLEAR);
   end

   assign state = run_state;

   // Fetch FSM: state register and captured command/ack bytes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         f_state <= F_IDLE;
         cmd_q   <= '0;
         tx_data <= '0;
      end else begin
         f_state <= f_next;
         if (rx_rd)
            cmd_q <= rx_data;
         if (uart_go && ACK_EN)
            tx_data <= ack_byte;
      end
   end

   // Fetch FSM: next state.
   always_comb begin
      f_next = f_state;
      case (f_state)
         F_IDLE:  if (!rx_empty) f_next = F_EXEC;
         F_EXEC:  if (uart_go) f_next = ACK_EN ? F_ACK : F_IDLE;
         F_ACK:   if (!tx_busy) f_next = F_IDLE;
         default: f_next = F_IDLE;
      endcase
   end

   // Fetch FSM: outputs. Ack judges acceptance against the run state at the moment of apply.
   always_comb begin
      rx_rd    = reset && (f_state == F_IDLE) && !rx_empty;
      tx_start = ACK_EN && (f_state == F_ACK) && !tx_busy;
      ack_byte = cmd_echo;
      if (uart_code == EV_NONE)
         ack_byte = ASC_QUES;
      else if ((run_state == RUN) && (uart_code != EV_RUN))
         ack_byte = ASC_DASH;
   end

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Directed bench for stopwatch_cmd_ctrl: FIFO model feeds commands, expected ack bytes
// are queued at push time and checked when tx_start fires.
module tb_stopwatch_cmd_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_run_stop = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_mode = 1'b0;
   logic       rx_empty = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       tx_busy = 1'b0;
   logic       rx_rd, tx_start, enable, clear, run_md;
   logic [7:0] tx_data;
   logic [1:0] state;

   int total = 0;
   int bad = 0;
   int rd_cnt = 0;
   int st_cnt = 0;
   int clr_cnt = 0;
   int rd0, st0, clr0;
   logic rd_seen = 1'b0;
   logic m_run = 1'b0;
   logic m_md = 1'b0;
   logic [7:0] ack_want;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   stopwatch_cmd_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .btn_run_stop (btn_run_stop),
      .btn_clear    (btn_clear),
      .btn_mode     (btn_mode),
      .rx_empty     (rx_empty),
      .rx_data      (rx_data),
      .rx_rd        (rx_rd),
      .tx_busy      (tx_busy),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .enable       (enable),
      .clear        (clear),
      .run_md       (run_md),
      .state        (state)
   );

   task automatic refresh();
      rx_empty = (fifo_q.size() == 0);
      rx_data  = rx_empty ? 8'h00 : fifo_q[0];
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference behaviour for a UART byte issued with no competing button event.
   task automatic push(input logic [7:0] b);
      logic [7:0] a;
      case (b)
         8'h52, 8'h72: begin a = 8'h52; m_run = !m_run; end
         8'h43, 8'h63: a = m_run ? 8'h2D : 8'h43;
         8'h4D, 8'h6D: begin a = m_run ? 8'h2D : 8'h4D; if (!m_run) m_md = !m_md; end
         default:      a = 8'h3F;
      endcase
      exp_q.push_back(a);
      fifo_q.push_back(b);
      refresh();
   endtask

   // FIFO pop: a read strobe seen in the cycle removes the head just after the edge.
   always @(posedge clk) begin
      #1;
      if (rd_seen && fifo_q.size() != 0) begin
         void'(fifo_q.pop_front());
         refresh();
      end
   end

   always @(negedge clk) begin
      rd_seen = rx_rd;
      if (rx_rd) rd_cnt++;
      if (clear) clr_cnt++;
      if (tx_start) begin
         st_cnt++;
         ack_want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         total++;
         assert (tx_data === ack_want) else begin
            bad++;
            $error("FAIL ack_byte: got %h want %h", tx_data, ack_want);
         end
      end
   end

   initial begin
      refresh();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_enable", enable, 0);
      chk("rst_clear", clear, 0);
      chk("rst_run_md", run_md, 0);
      chk("rst_rx_rd", rx_rd, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      reset = 1'b1;
      settle(2);

      // Button run/stop: visible two cycles after the input edge.
      tick(); btn_run_stop = 1'b1; m_run = 1'b1;
      settle(2); chk("btn_run_early", state, 0);
      settle(1); chk("btn_run_state", state, 1); chk("btn_run_enable", enable, 1);
      tick(); btn_run_stop = 1'b0;
      settle(2);
      tick(); btn_run_stop = 1'b1; m_run = 1'b0;
      settle(3); chk("btn_stop_state", state, 0); chk("btn_stop_enable", enable, 0);
      tick(); btn_run_stop = 1'b0;
      settle(2);

      // 'C' in STOP: one pop, one clear pulse, ack 'C'.
      clr0 = clr_cnt; rd0 = rd_cnt;
      tick(); push(8'h43);
      settle(1); chk("clr_rx_rd", rx_rd, 1);
      settle(1); chk("clr_rx_rd_once", rx_rd, 0);
      settle(1); chk("clr_state", state, 2); chk("clr_pulse", clear, 1); chk("clr_tx_start", tx_start, 1);
      settle(1); chk("clr_back_stop", state, 0); chk("clr_pulse_end", clear, 0);
      settle(4); chk("clr_count", clr_cnt - clr0, 1); chk("clr_pops", rd_cnt - rd0, 1);

      // In RUN, clear and mode commands are rejected.
      tick(); btn_run_stop = 1'b1; m_run = 1'b1;
      settle(3);
      tick(); btn_run_stop = 1'b0;
      clr0 = clr_cnt;
      tick(); push(8'h63);
      settle(6); chk("rej_c_enable", enable, 1); chk("rej_c_state", state, {1'b0, m_run});
      chk("rej_c_noclear", clr_cnt - clr0, 0);
      tick(); push(8'h4D);
      settle(6); chk("rej_m_run_md", run_md, 0);

      // Lowercase 'r' stops; unknown byte ignored; 'm' toggles mode in STOP.
      tick(); push(8'h72);
      settle(6); chk("r_stop_state", state, {1'b0, m_run}); chk("r_stop_enable", enable, 0);
      tick(); push(8'h41);
      settle(6); chk("unk_state", state, 0);
      tick(); push(8'h6D);
      settle(6); chk("mode_run_md", run_md, m_md);
      chk("sb_empty_1", exp_q.size(), 0);

      // Button clear collides with a UART 'R' in execution: clear first, then run.
      clr0 = clr_cnt;
      tick(); push(8'h52); btn_clear = 1'b1;
      settle(3); chk("coll_clear_first", state, 2);
      settle(2); chk("coll_final_run", state, 1); chk("coll_enable", enable, 1);
      tick(); btn_clear = 1'b0;
      settle(4); chk("coll_clr_count", clr_cnt - clr0, 1);

      // Back-pressure: TX busy stalls after a single pop.
      rd0 = rd_cnt; st0 = st_cnt;
      tick(); tx_busy = 1'b1; push(8'h41); push(8'h41); push(8'h41);
      settle(12);
      chk("bp_one_pop", rd_cnt - rd0, 1);
      chk("bp_no_start", st_cnt - st0, 0);
      chk("bp_state", state, 1);
      tick(); tx_busy = 1'b0;
      settle(20);
      chk("bp_all_pops", rd_cnt - rd0, 3);
      chk("bp_all_acks", st_cnt - st0, 3);
      chk("sb_empty_2", exp_q.size(), 0);

      // Reset in the middle of F_ACK drops the pending ack.
      tick(); tx_busy = 1'b1; push(8'h52);
      settle(5);
      tick(); reset = 1'b0;
      void'(exp_q.pop_back());
      m_run = 1'b0; m_md = 1'b0;
      #1;
      chk("mid_rst_state", state, 0);
      chk("mid_rst_enable", enable, 0);
      chk("mid_rst_run_md", run_md, 0);
      chk("mid_rst_tx_start", tx_start, 0);
      chk("mid_rst_tx_data", tx_data, 0);
      chk("mid_rst_rx_rd", rx_rd, 0);
      tick(); reset = 1'b1; tx_busy = 1'b0;
      rd0 = rd_cnt; st0 = st_cnt;
      settle(10);
      chk("post_rst_no_start", st_cnt - st0, 0);
      chk("post_rst_no_pop", rd_cnt - rd0, 0);
      chk("post_rst_state", state, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
